multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
- Execute-stage sequencer sitting directly upstream of the iterative multiply/divide unit.
- Accepts a MULT/DIV instruction from the pipeline, latches its operands and destination, issues a single-cycle start pulse to the unit, and stalls the pipeline until the unit signals ready.
- Then presents one writeback beat: either the result to rd, or an rstatus code to $r30 on exception.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, register index width.
- TIMEOUT_CYCLES, 40, cycles in WAIT before a forced timeout (only with the optional feature).

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- issue_valid  in  1  MULT/DIV instruction present in execute.
- issue_is_div  in  1  0=MULT, 1=DIV.
- issue_a  in  DATA_W  operand A (multiplicand/dividend).
- issue_b  in  DATA_W  operand B (multiplier/divisor).
- issue_rd  in  REG_W  destination register.
- flush  in  1  pipeline flush; aborts any in-flight operation.
- stall  out  1  hold upstream stages.
- md_operandA, md_operandB  out  DATA_W  registered operands to the unit.
- md_ctrl_MULT, md_ctrl_DIV  out  1  one-cycle start pulses.
- md_result  in  DATA_W  unit result.
- md_exception  in  1  unit exception (overflow / divide-by-zero).
- md_resultRDY  in  1  unit ready.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  REG_W  writeback register.
- wb_data  out  DATA_W  writeback value.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE.
  - stall, md_ctrl_MULT, md_ctrl_DIV and wb_valid all 0.
  - md_operandA/B, wb_rd and wb_data all 0.
- IDLE:
  - If issue_valid=1 and flush=0: latch a, b, is_div and rd, then go to START.
  - stall is 1 combinationally in the accept cycle and stays 1 through START and WAIT.
- START (exactly 1 cycle): drive md_ctrl_MULT=!is_div and md_ctrl_DIV=is_div; md_resultRDY is ignored in this cycle; go to WAIT.
- WAIT: remain until md_resultRDY=1, then go to DONE and capture the outcome:
  - md_exception=0: wb_data=md_result, wb_rd=latched rd.
  - md_exception=1: wb_rd=30, wb_data=4 for MULT or 5 for DIV.
- DONE (1 cycle): wb_valid=1 and stall=0, so upstream advances this cycle; next state is IDLE.
  - A new issue is not accepted in DONE; it is accepted in the following IDLE cycle.
- Latency: accept at edge N, start pulse in cycle N+1, wb_valid in the cycle after the edge at which md_resultRDY is sampled high.
- Start pulses are never asserted outside START; both pulses are never high together.
- md_resultRDY seen in IDLE or DONE is ignored (stale ready from an aborted op).
- flush=1 in START or WAIT:
  - Next state IDLE; no wb_valid; stall drops the following cycle.
  - The unit restarts on the next start pulse.
- flush=1 together with issue_valid in IDLE: the issue is not accepted.
- flush in DONE: wb_valid is still emitted; writeback squashing is the consumer's job.
- issue_valid while stall=1: ignored; upstream holds the instruction.

Optional Feature:
- Macro: MULTDIV_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without md_resultRDY, go to DONE with wb_rd=30, wb_data=6.
  - If RDY and the terminal count coincide, RDY wins.
- Undefined: no counter; WAIT is unbounded.

Decomposition:
- Package multdiv_pkg:
  - state encoding IDLE/START/WAIT/DONE;
  - RSTATUS_REG=30;
  - RSTATUS_MULT_OVF=4, RSTATUS_DIV_ZERO=5, RSTATUS_TIMEOUT=6.
- One natural sub-module: md_wait_counter (clear/enable/terminal-count), instantiated only under MULTDIV_TIMEOUT_EN.

Test Plan:
- MULT a=6, b=7, rd=3; unit returns RDY with result 42, exc=0:
  - one MULT pulse, none on DIV;
  - stall high until the DONE cycle;
  - wb_valid once with rd=3, data=42.
- DIV a=100, b=0, rd=8; unit returns exc=1 -> wb_rd=30, wb_data=5, one strobe.
- MULT 0x7FFFFFFF*2 with exc=1 -> wb_rd=30, wb_data=4.
- flush during WAIT, then stale RDY next cycle in IDLE:
  - no wb_valid;
  - stall=0 after flush;
  - the next DIV issues a fresh pulse and writes back correctly.
- Reset asserted mid-WAIT -> all outputs 0 next cycle, state IDLE; held issue_valid is accepted after reset_n returns high.
- With MULTDIV_TIMEOUT_EN, no RDY for 40 cycles -> wb_rd=30, wb_data=6; RDY arriving on cycle 40 -> normal result instead.

Source files
------------

// File: rtl/multdiv_pkg.sv
//------------------------------------------------------------------------------
// Module   : multdiv_pkg
// Brief    : Shared state encoding and rstatus codes for the MULT/DIV issue
//            sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multdiv_pkg;

  // Sequencer states: accept -> pulse the unit -> wait for ready -> write back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } md_state_e;

  // Exceptions are reported by writing a status code into $r30.
  localparam int RSTATUS_REG      = 30;
  localparam int RSTATUS_MULT_OVF = 4;
  localparam int RSTATUS_DIV_ZERO = 5;
  localparam int RSTATUS_TIMEOUT  = 6;

  // Status code for a unit-reported exception, chosen by operation type.
  function automatic int exc_code(input logic is_div);
    return is_div ? RSTATUS_DIV_ZERO : RSTATUS_MULT_OVF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_wait_counter.sv
//------------------------------------------------------------------------------
// Module   : md_wait_counter
// Brief    : Watchdog cycle counter for the WAIT state. Cleared while the
//            start pulse is issued, counts each WAIT cycle, and flags the
//            last allowed WAIT cycle through tc.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_wait_counter #(
  parameter int unsigned TERMINAL = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = $clog2(TERMINAL + 1);

  logic [CW-1:0] count;

  // Count WAIT cycles; holds at the terminal value until cleared.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + CW'(1);
    end
  end

  // Count is zero in the first WAIT cycle, so TERMINAL-1 marks the last one.
  assign tc = (count == CW'(TERMINAL - 1));

endmodule

`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : multdiv_issue_ctrl
// Brief    : Execute-stage sequencer in front of the iterative multiply/divide
//            unit. Latches one MULT/DIV, pulses the unit, stalls the pipeline
//            until ready, then emits a single writeback beat (result to rd or
//            an rstatus code to $r30 on exception).
// Options  : `define MULTDIV_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES and
//            report RSTATUS_TIMEOUT when the unit never answers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] md_operandA,
  output logic [DATA_W-1:0] md_operandB,
  output logic              md_ctrl_MULT,
  output logic              md_ctrl_DIV,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  md_state_e        state;
  md_state_e        state_next;
  logic             is_div_q;
  logic [REG_W-1:0] rd_q;
  logic             accept;
  logic             in_wait;
  logic             finish_ok;
  logic             finish_timeout;
  logic             timeout_tc;

  // Gating with reset_n keeps stall low while reset is held, even if the
  // pipeline keeps presenting an instruction.
  assign accept  = (state == IDLE) && issue_valid && !flush && reset_n;
  assign in_wait = (state == WAIT) && !flush;

  // Ready has priority over the watchdog when both land in the same cycle.
  assign finish_ok      = in_wait && md_resultRDY;
  assign finish_timeout = in_wait && !md_resultRDY && timeout_tc;

`ifdef MULTDIV_TIMEOUT_EN
  md_wait_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == START),
    .enable  (state == WAIT),
    .tc      (timeout_tc)
  );
`else
  // Without the watchdog WAIT is unbounded; the timeout length has no effect.
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_tc            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs; ready outside WAIT is treated as stale.
  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) begin
          state_next = START;
        end
      end
      START: begin
        stall        = 1'b1;
        md_ctrl_MULT = !is_div_q;
        md_ctrl_DIV  = is_div_q;
        state_next   = flush ? IDLE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else if (finish_ok || finish_timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        wb_valid   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand/destination latch on accept and writeback capture on completion.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      md_operandA <= '0;
      md_operandB <= '0;
      is_div_q    <= 1'b0;
      rd_q        <= '0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      if (accept) begin
        md_operandA <= issue_a;
        md_operandB <= issue_b;
        is_div_q    <= issue_is_div;
        rd_q        <= issue_rd;
      end
      if (finish_ok) begin
        if (md_exception) begin
          wb_rd   <= REG_W'(RSTATUS_REG);
          wb_data <= DATA_W'(exc_code(is_div_q));
        end else begin
          wb_rd   <= rd_q;
          wb_data <= md_result;
        end
      end else if (finish_timeout) begin
        wb_rd   <= REG_W'(RSTATUS_REG);
        wb_data <= DATA_W'(RSTATUS_TIMEOUT);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_multdiv_issue_ctrl
// Brief    : Directed self-checking bench for multdiv_issue_ctrl. The bench
//            plays the role of the multiply/divide unit by hand.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        stall;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;
  int mult_pulses = 0;
  int div_pulses  = 0;
  int both_high   = 0;
  int wb_count    = 0;

  multdiv_issue_ctrl #(
    .DATA_W         (32),
    .REG_W          (5),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_is_div (issue_is_div),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .stall        (stall),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clock = ~clock;

  // Pulse and strobe tallies, sampled mid-cycle.
  always @(negedge clock) begin
    if (md_ctrl_MULT) mult_pulses++;
    if (md_ctrl_DIV) div_pulses++;
    if (md_ctrl_MULT && md_ctrl_DIV) both_high++;
    if (wb_valid) wb_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_tally();
    mult_pulses = 0;
    div_pulses  = 0;
    both_high   = 0;
    wb_count    = 0;
  endtask

  // From an IDLE slot: issue, run START plus (1 + waits) WAIT cycles, return
  // ready with res/exc, and stop settled inside the DONE cycle.
  task automatic do_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int waits,
                       input logic [31:0] res, input logic exc);
    issue_valid  = 1'b1;
    issue_is_div = d;
    issue_a      = a;
    issue_b      = b;
    issue_rd     = rd;
    cyc();
    issue_valid = 1'b0;
    cyc();
    repeat (waits) cyc();
    md_resultRDY = 1'b1;
    md_result    = res;
    md_exception = exc;
    cyc();
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    issue_valid  = 1'b0;
    issue_is_div = 1'b0;
    issue_a      = '0;
    issue_b      = '0;
    issue_rd     = '0;
    flush        = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    cyc();
    cyc();
    settle();
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_pulses", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_opA", md_operandA, 32'd0);
    check_eq("rst_wb", 32'({wb_rd, wb_data}), 32'd0);
    reset_n = 1'b1;

    // MULT 6*7 -> rd3 = 42, with a spurious ready during START.
    cyc();
    clear_tally();
    issue_valid  = 1'b1;
    issue_is_div = 1'b0;
    issue_a      = 32'd6;
    issue_b      = 32'd7;
    issue_rd     = 5'd3;
    settle();
    check_eq("accept_stall", 32'(stall), 32'd1);
    cyc();
    issue_valid  = 1'b0;
    md_resultRDY = 1'b1;
    md_result    = 32'd999;
    settle();
    check_eq("start_mult", 32'(md_ctrl_MULT), 32'd1);
    check_eq("start_div", 32'(md_ctrl_DIV), 32'd0);
    check_eq("start_opA", md_operandA, 32'd6);
    check_eq("start_opB", md_operandB, 32'd7);
    cyc();
    md_resultRDY = 1'b0;
    settle();
    check_eq("wait_no_wb", 32'(wb_valid), 32'd0);
    check_eq("wait_stall", 32'(stall), 32'd1);
    check_eq("wait_no_pulse", 32'(md_ctrl_MULT), 32'd0);
    cyc();
    cyc();
    md_resultRDY = 1'b1;
    md_result    = 32'd42;
    cyc();
    md_resultRDY = 1'b0;
    // Next instruction already presented in DONE must not be taken yet.
    issue_valid  = 1'b1;
    issue_is_div = 1'b1;
    issue_a      = 32'd100;
    issue_b      = 32'd0;
    issue_rd     = 5'd8;
    settle();
    check_eq("done_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("done_wb_rd", 32'(wb_rd), 32'd3);
    check_eq("done_wb_data", wb_data, 32'd42);
    check_eq("mult_pulses", 32'(mult_pulses), 32'd1);
    check_eq("mult_div_pulses", 32'(div_pulses), 32'd0);

    // DIV 100/0 accepted in the IDLE after DONE; exception -> r30 = 5.
    cyc();
    settle();
    check_eq("idle_accept_stall", 32'(stall), 32'd1);
    check_eq("idle_no_wb", 32'(wb_valid), 32'd0);
    cyc();
    issue_valid = 1'b0;
    settle();
    check_eq("div_pulse", 32'(md_ctrl_DIV), 32'd1);
    check_eq("div_opA", md_operandA, 32'd100);
    cyc();
    md_resultRDY = 1'b1;
    md_exception = 1'b1;
    md_result    = 32'd123;
    cyc();
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    settle();
    check_eq("divz_wb_rd", 32'(wb_rd), 32'd30);
    check_eq("divz_wb_data", wb_data, 32'd5);
    cyc();
    check_eq("divz_strobes", 32'(wb_count), 32'd2);
    check_eq("divz_div_pulses", 32'(div_pulses), 32'd1);

    // MULT overflow -> r30 = 4; flush in DONE leaves the strobe intact.
    do_op(1'b0, 32'h7FFF_FFFF, 32'd2, 5'd12, 2, 32'hFFFF_FFFE, 1'b1);
    flush = 1'b1;
    settle();
    check_eq("ovf_wb_rd", 32'(wb_rd), 32'd30);
    check_eq("ovf_wb_data", wb_data, 32'd4);
    check_eq("done_flush_wb", 32'(wb_valid), 32'd1);
    cyc();
    // Flush with an issue in IDLE: not accepted.
    issue_valid  = 1'b1;
    issue_is_div = 1'b0;
    settle();
    check_eq("flush_issue_stall", 32'(stall), 32'd0);
    cyc();
    issue_valid = 1'b0;
    flush       = 1'b0;
    settle();
    check_eq("flush_issue_no_pulse", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);

    // Flush during WAIT, then a stale ready in IDLE.
    cyc();
    clear_tally();
    issue_valid  = 1'b1;
    issue_is_div = 1'b1;
    issue_a      = 32'd77;
    issue_b      = 32'd7;
    issue_rd     = 5'd6;
    cyc();
    issue_valid = 1'b0;
    cyc();
    cyc();
    flush = 1'b1;
    cyc();
    flush        = 1'b0;
    md_resultRDY = 1'b1;
    md_result    = 32'd777;
    settle();
    check_eq("flush_stall_drop", 32'(stall), 32'd0);
    check_eq("flush_no_wb", 32'(wb_valid), 32'd0);
    cyc();
    md_resultRDY = 1'b0;
    settle();
    check_eq("stale_rdy_no_wb", 32'(wb_valid), 32'd0);
    check_eq("stale_rdy_stall", 32'(stall), 32'd0);
    do_op(1'b1, 32'd50, 32'd5, 5'd9, 1, 32'd10, 1'b0);
    check_eq("refresh_wb_rd", 32'(wb_rd), 32'd9);
    check_eq("refresh_wb_data", wb_data, 32'd10);
    cyc();
    check_eq("refresh_div_pulses", 32'(div_pulses), 32'd2);
    check_eq("refresh_strobes", 32'(wb_count), 32'd1);

    // Reset mid-WAIT with an instruction held across reset.
    issue_valid  = 1'b1;
    issue_is_div = 1'b0;
    issue_a      = 32'd1;
    issue_b      = 32'd2;
    issue_rd     = 5'd4;
    cyc();
    issue_valid = 1'b0;
    cyc();
    cyc();
    reset_n      = 1'b0;
    issue_valid  = 1'b1;
    issue_is_div = 1'b1;
    issue_a      = 32'd11;
    issue_b      = 32'd12;
    issue_rd     = 5'd5;
    cyc();
    settle();
    check_eq("midrst_stall", 32'(stall), 32'd0);
    check_eq("midrst_pulses", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
    check_eq("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("midrst_ops", md_operandA | md_operandB, 32'd0);
    check_eq("midrst_wb", 32'({wb_rd, wb_data}), 32'd0);
    reset_n = 1'b1;
    settle();
    check_eq("postrst_accept", 32'(stall), 32'd1);
    cyc();
    issue_valid = 1'b0;
    settle();
    check_eq("postrst_div_pulse", 32'(md_ctrl_DIV), 32'd1);
    check_eq("postrst_opA", md_operandA, 32'd11);
    cyc();
    md_resultRDY = 1'b1;
    md_result    = 32'h1234;
    cyc();
    md_resultRDY = 1'b0;
    settle();
    check_eq("postrst_wb_rd", 32'(wb_rd), 32'd5);
    check_eq("postrst_wb_data", wb_data, 32'h1234);
    cyc();

`ifdef MULTDIV_TIMEOUT_EN
    // No ready for TIMEOUT WAIT cycles -> r30 = 6.
    issue_valid  = 1'b1;
    issue_is_div = 1'b0;
    issue_rd     = 5'd7;
    cyc();
    issue_valid = 1'b0;
    cyc();
    repeat (TIMEOUT - 1) cyc();
    settle();
    check_eq("to_last_wait_stall", 32'(stall), 32'd1);
    check_eq("to_last_wait_no_wb", 32'(wb_valid), 32'd0);
    cyc();
    settle();
    check_eq("to_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("to_wb_rd", 32'(wb_rd), 32'd30);
    check_eq("to_wb_data", wb_data, 32'd6);
    cyc();
    // Ready on the terminal WAIT cycle wins over the timeout.
    do_op(1'b1, 32'd9, 32'd3, 5'd14, TIMEOUT - 1, 32'hABCD, 1'b0);
    check_eq("to_race_wb_rd", 32'(wb_rd), 32'd14);
    check_eq("to_race_wb_data", wb_data, 32'hABCD);
    cyc();
`else
    // Without the watchdog, a long WAIT keeps stalling.
    clear_tally();
    issue_valid  = 1'b1;
    issue_is_div = 1'b0;
    issue_rd     = 5'd7;
    cyc();
    issue_valid = 1'b0;
    cyc();
    repeat (TIMEOUT + 20) cyc();
    settle();
    check_eq("long_wait_stall", 32'(stall), 32'd1);
    check_eq("long_wait_no_wb", 32'(wb_count), 32'd0);
    md_resultRDY = 1'b1;
    md_result    = 32'hABCD;
    cyc();
    md_resultRDY = 1'b0;
    settle();
    check_eq("long_wait_wb_rd", 32'(wb_rd), 32'd7);
    check_eq("long_wait_wb_data", wb_data, 32'hABCD);
    cyc();
`endif

    check_eq("never_both_pulses", 32'(both_high), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
